// File: rtl/oled_spi_arbiter.sv
// Two-port arbiter in front of a single SPI byte master: one byte transfer at a time,
// round-robin on ties, port 1 gated by init_done, watchdog abort on a lost completion.
module oled_spi_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_W          = 10
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic       init_done_i,
  input  logic       r0_send_i,
  input  logic [7:0] r0_data_i,
  input  logic       r0_dc_i,
  output logic       r0_done_o,
  input  logic       r1_send_i,
  input  logic [7:0] r1_data_i,
  input  logic       r1_dc_i,
  output logic       r1_done_o,
  output logic       spi_send_o,
  output logic [7:0] spi_data_o,
  output logic       dc_o,
  input  logic       spi_send_done_i,
  output logic       busy_o,
  output logic       timeout_o
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  localparam logic [CNT_W-1:0] WdLast = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic             to_q, to_d;
  logic [7:0]       data_q, data_d;
  logic             dc_q, dc_d;
  logic [CNT_W-1:0] wd_q, wd_d;
  logic [CNT_W-1:0] wd_inc;
  logic             elig0, elig1, win;

  assign elig0  = r0_send_i;
  assign elig1  = r1_send_i & init_done_i;
  // On a tie the port that did not finish last wins; a lone requester always wins.
  assign win    = elig1 & (~elig0 | ~last_q);
  assign wd_inc = wd_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    to_d    = to_q;
    data_d  = data_q;
    dc_d    = dc_q;
    wd_d    = wd_q;
    unique case (state_q)
      StIdle: begin
        if (elig0 | elig1) begin
          owner_d = win;
          data_d  = win ? r1_data_i : r0_data_i;
          dc_d    = win ? r1_dc_i : r0_dc_i;
          state_d = StIssue;
        end
      end
      StIssue: begin
        wd_d    = '0;
        to_d    = 1'b0;
        state_d = StWait;
      end
      StWait: begin
        if (spi_send_done_i) begin
          to_d    = 1'b0;
          state_d = StDone;
        end else begin
          wd_d = wd_inc;
          if (wd_inc == WdLast) begin
            to_d    = 1'b1;
            state_d = StDone;
          end
        end
      end
      StDone: begin
        last_d  = owner_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= StIdle;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      to_q    <= 1'b0;
      data_q  <= 8'h00;
      dc_q    <= 1'b0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      to_q    <= to_d;
      data_q  <= data_d;
      dc_q    <= dc_d;
      wd_q    <= wd_d;
    end
  end

  assign spi_send_o = (state_q == StIssue);
  assign r0_done_o  = (state_q == StDone) & ~owner_q;
  assign r1_done_o  = (state_q == StDone) & owner_q;
  assign timeout_o  = (state_q == StDone) & to_q;
  assign busy_o     = (state_q != StIdle);
  assign spi_data_o = data_q;
  assign dc_o       = dc_q;

endmodule

// File: tb/tb_oled_spi_arbiter.sv
// Bench for oled_spi_arbiter: transaction-level model of grant order, byte latching
// and done/timeout timing, driven by directed scenarios and random request mixes.
module tb_oled_spi_arbiter;

  localparam int unsigned TO = 8;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       init_done = 1'b0;
  logic       r0_send = 1'b0, r0_dc = 1'b0, r1_send = 1'b0, r1_dc = 1'b0;
  logic [7:0] r0_data = 8'h00, r1_data = 8'h00;
  logic       spi_send_done = 1'b0;
  logic       r0_done, r1_done, spi_send, dc, busy, timeout;
  logic [7:0] spi_data;

  int checks = 0;
  int errors = 0;
  int mdl_last = 1;

  always #5 clk = ~clk;

  oled_spi_arbiter #(
    .TIMEOUT_CYCLES(TO),
    .CNT_W         (4)
  ) dut (
    .clk_i          (clk),
    .reset_n_i      (reset_n),
    .init_done_i    (init_done),
    .r0_send_i      (r0_send),
    .r0_data_i      (r0_data),
    .r0_dc_i        (r0_dc),
    .r0_done_o      (r0_done),
    .r1_send_i      (r1_send),
    .r1_data_i      (r1_data),
    .r1_dc_i        (r1_dc),
    .r1_done_o      (r1_done),
    .spi_send_o     (spi_send),
    .spi_data_o     (spi_data),
    .dc_o           (dc),
    .spi_send_done_i(spi_send_done),
    .busy_o         (busy),
    .timeout_o      (timeout)
  );

  // One byte transfer using the request inputs as currently driven. lat is the number of
  // negedges from the call to spi_send; dly is the cycle (after spi_send) in which
  // spi_send_done is pulsed, 0 = never; spur adds a stray done pulse during ISSUE.
  task automatic xfer(input int lat, input int dly, input bit spur, output logic [7:0] got);
    int win, exp_k, k, seen;
    bit el0, el1, eto, bad;
    logic [7:0] ed, s0, s1;
    logic edc;
    el0 = r0_send;
    el1 = r1_send && init_done;
    if (el0 && el1) win = (mdl_last == 0) ? 1 : 0;
    else win = el0 ? 0 : 1;
    ed  = (win == 1) ? r1_data : r0_data;
    edc = (win == 1) ? r1_dc : r0_dc;
    if (dly == 0 || dly >= int'(TO)) begin
      exp_k = TO; eto = 1'b1;
    end else begin
      exp_k = dly + 1; eto = 1'b0;
    end
    seen = 0;
    for (int i = 1; i <= 4 && seen == 0; i++) begin
      @(negedge clk);
      if (spi_send) seen = i;
    end
    got = spi_data;
    checks++;
    if (seen != lat) begin
      errors++; $display("FAIL send_latency: got %0d want %0d", seen, lat);
    end
    checks++;
    if (spi_data !== ed || dc !== edc) begin
      errors++; $display("FAIL grant_data: got %h/%b want %h/%b", spi_data, dc, ed, edc);
    end
    if (spur) spi_send_done = 1'b1;
    s0 = r0_data; s1 = r1_data;
    k = 0; seen = 0; bad = 1'b0;
    while (seen == 0 && k < int'(TO) + 4) begin
      @(negedge clk);
      k++;
      spi_send_done = (k == dly);
      if (k == 2) begin r0_data = ~s0; r1_data = ~s1; end
      if (!busy || spi_send) bad = 1'b1;
      if (r0_done || r1_done) seen = 1;
    end
    spi_send_done = 1'b0;
    checks++;
    if (bad) begin
      errors++; $display("FAIL busy_protocol: busy/spi_send wrong during transfer");
    end
    checks++;
    if (k != exp_k) begin
      errors++; $display("FAIL done_latency: got %0d want %0d", k, exp_k);
    end
    checks++;
    if ({r1_done, r0_done} !== ((win == 1) ? 2'b10 : 2'b01)) begin
      errors++; $display("FAIL done_owner: got %b want port %0d", {r1_done, r0_done}, win);
    end
    checks++;
    if (timeout !== eto) begin
      errors++; $display("FAIL timeout_flag: got %b want %b", timeout, eto);
    end
    checks++;
    if (spi_data !== ed || dc !== edc) begin
      errors++; $display("FAIL data_hold: got %h/%b want %h/%b", spi_data, dc, ed, edc);
    end
    r0_data = s0; r1_data = s1;
    mdl_last = win;
  endtask

  task automatic expect_quiet(input int n);
    bit bad;
    bad = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (spi_send || busy || r0_done || r1_done || timeout) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL quiet: activity seen while no eligible request");
    end
  endtask

  task automatic go_idle();
    r0_send = 1'b0; r1_send = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL idle_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; r0_send = 1'b0; r1_send = 1'b0; spi_send_done = 1'b0;
    @(negedge clk);
    checks++;
    if ({spi_send, busy, r0_done, r1_done, timeout, dc} !== 6'b0 || spi_data !== 8'h00) begin
      errors++; $display("FAIL reset_outputs: got %b/%h want 0", {spi_send, busy, r0_done,
                         r1_done, timeout, dc}, spi_data);
    end
    @(negedge clk);
    reset_n = 1'b1;
    mdl_last = 1;
  endtask

  task automatic test_init_lock();
    logic [7:0] d;
    test_reset();
    init_done = 1'b0;
    r0_send = 1'b1; r0_data = 8'hAE; r0_dc = 1'b0;
    r1_send = 1'b1; r1_data = 8'h55; r1_dc = 1'b1;
    xfer(1, 4, 1'b0, d);
    checks++;
    if (d !== 8'hAE) begin errors++; $display("FAIL init_byte: got %h want ae", d); end
    r0_send = 1'b0;
    @(negedge clk);
    expect_quiet(6);
    init_done = 1'b1;
    xfer(1, 3, 1'b0, d);
    go_idle();
  endtask

  task automatic test_round_robin();
    logic [7:0] got[4];
    logic [7:0] want[4];
    want = '{8'h01, 8'h81, 8'h02, 8'h82};
    test_reset();
    init_done = 1'b1;
    r0_send = 1'b1; r0_data = 8'h01; r0_dc = 1'b0;
    r1_send = 1'b1; r1_data = 8'h81; r1_dc = 1'b1;
    xfer(1, 3, 1'b0, got[0]);
    r0_data = 8'h02;
    xfer(2, 2, 1'b0, got[1]);
    r1_data = 8'h82;
    xfer(2, 4, 1'b0, got[2]);
    xfer(2, 1, 1'b0, got[3]);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (got[i] !== want[i]) begin
        errors++; $display("FAIL rr_order[%0d]: got %h want %h", i, got[i], want[i]);
      end
    end
    go_idle();
  endtask

  task automatic test_port1_only();
    logic [7:0] d;
    init_done = 1'b1;
    r1_send = 1'b1; r1_data = 8'h3C; r1_dc = 1'b1;
    xfer(1, 5, 1'b0, d);
    go_idle();
  endtask

  task automatic test_timeout();
    logic [7:0] d;
    r0_send = 1'b1; r0_data = 8'hC3; r0_dc = 1'b1;
    xfer(1, 0, 1'b0, d);
    r0_data = 8'h5A; r0_dc = 1'b0;
    xfer(2, 3, 1'b0, d);
    go_idle();
  endtask

  task automatic test_spurious();
    logic [7:0] d;
    spi_send_done = 1'b1;
    @(negedge clk);
    spi_send_done = 1'b0;
    checks++;
    if (busy || r0_done || r1_done || spi_send) begin
      errors++; $display("FAIL spurious_idle: got busy=%b done=%b%b", busy, r1_done, r0_done);
    end
    expect_quiet(2);
    r0_send = 1'b1; r0_data = 8'h77; r0_dc = 1'b0;
    xfer(1, 3, 1'b1, d);
    go_idle();
  endtask

  task automatic test_reset_mid_wait();
    logic [7:0] d;
    int seen;
    test_reset();
    init_done = 1'b1;
    r0_send = 1'b1; r0_data = 8'h11; r0_dc = 1'b0;
    xfer(1, 2, 1'b0, d);
    r1_send = 1'b1; r1_data = 8'h22; r1_dc = 1'b1;
    seen = 0;
    for (int i = 1; i <= 4 && seen == 0; i++) begin
      @(negedge clk);
      if (spi_send) seen = i;
    end
    checks++;
    if (seen != 2 || spi_data !== 8'h22) begin
      errors++; $display("FAIL pre_reset_grant: got %0d/%h want 2/22", seen, spi_data);
    end
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++;
    if ({spi_send, busy, r0_done, r1_done, timeout, dc} !== 6'b0 || spi_data !== 8'h00) begin
      errors++; $display("FAIL async_reset: got %b/%h want 0", {spi_send, busy, r0_done,
                         r1_done, timeout, dc}, spi_data);
    end
    @(negedge clk);
    reset_n = 1'b1;
    mdl_last = 1;
    xfer(1, 2, 1'b0, d);
    checks++;
    if (d !== 8'h11) begin errors++; $display("FAIL post_reset_tie: got %h want 11", d); end
    go_idle();
  endtask

  task automatic test_random();
    logic [7:0] d;
    int dly;
    for (int it = 0; it < 30; it++) begin
      init_done = 1'($urandom_range(0, 1));
      r0_send   = 1'($urandom_range(0, 1));
      r1_send   = 1'($urandom_range(0, 1));
      r0_data   = 8'($urandom);
      r1_data   = 8'($urandom);
      r0_dc     = 1'($urandom_range(0, 1));
      r1_dc     = 1'($urandom_range(0, 1));
      dly = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 6));
      if (r0_send || (r1_send && init_done)) begin
        xfer(1, dly, 1'($urandom_range(0, 1)), d);
        go_idle();
      end else begin
        expect_quiet(3);
      end
    end
  endtask

  initial begin
    test_reset();
    test_init_lock();
    test_round_robin();
    test_port1_only();
    test_timeout();
    test_spurious();
    test_reset_mid_wait();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
